dino_autopilot: RTL

//  Parametrised autopilot for the dino runner. Scans N_OBS obstacle slots against a speed-scaled

---
 rtl/dino_autopilot.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dino_autopilot.sv
// Dino runner autopilot: scans obstacle slots against a speed-scaled trigger
// window and drives the jump/duck/start buttons. A connected gamepad always
// takes over. All state advances only on game_tick.
module dino_autopilot #(
   parameter int N_OBS         = 2,
   parameter int POS_W         = 10,
   parameter int PLAYER_OFFSET = 6,
   parameter int BASE_THRESH   = 40,
   parameter int SPEED_W       = 4,
   parameter int SPEED_GAIN    = 4,
   parameter int JUMP_HOLD     = 8,
   parameter int RESTART_DELAY = 60
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     game_tick,
   input  logic                     gamepad_is_present,
   input  logic                     gamepad_start,
   input  logic                     gamepad_up,
   input  logic                     gamepad_down,
   input  logic [N_OBS*POS_W-1:0]   obs_pos,
   input  logic [N_OBS-1:0]         obs_high,
   input  logic [SPEED_W-1:0]       speed,
   input  logic                     crash,
   input  logic                     game_frozen,
   output logic                     button_start,
   output logic                     button_up,
   output logic                     button_down,
   output logic                     ai_active,
   output logic [1:0]               dbg_state
);

   localparam int THR_W  = POS_W + 1;
   localparam int CNT_W  = $clog2(RESTART_DELAY + 1);
   localparam int HOLD_W = $clog2(JUMP_HOLD + 1);

   localparam logic [THR_W-1:0]  THR_MAX    = THR_W'((1 << POS_W) - 1);
   localparam logic [POS_W-1:0]  OFFSET     = POS_W'(PLAYER_OFFSET);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(RESTART_DELAY);
   localparam logic [HOLD_W-1:0] HOLD_START = HOLD_W'(JUMP_HOLD - 1);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_JUMP = 2'd1,
      S_DUCK = 2'd2,
      S_WAIT = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                start_q, start_d;
   logic                up_q, up_d;
   logic                down_q, down_d;
   logic                ai_q, ai_d;

   logic [THR_W-1:0]    thr_raw;
   logic [POS_W-1:0]    thr;
   logic                gnd_hit;
   logic                air_hit;

   // Trigger window upper bound grows with speed and clamps to the largest position.
   always_comb begin
      thr_raw = THR_W'(BASE_THRESH) + THR_W'(speed) * THR_W'(SPEED_GAIN);
      thr     = (thr_raw > THR_MAX) ? THR_MAX[POS_W-1:0] : thr_raw[POS_W-1:0];
   end

   // Classify every in-window obstacle as ground (jump) or airborne (duck).
   always_comb begin
      gnd_hit = 1'b0;
      air_hit = 1'b0;
      for (int i = 0; i < N_OBS; i++) begin
         if ((obs_pos[i*POS_W +: POS_W] > OFFSET) && (obs_pos[i*POS_W +: POS_W] <= thr)) begin
            if (obs_high[i]) air_hit = 1'b1;
            else             gnd_hit = 1'b1;
         end
      end
   end

   // Next-state and next-output decision, evaluated only on a frame strobe.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      start_d = start_q;
      up_d    = up_q;
      down_d  = down_q;
      ai_d    = ai_q;
      if (game_tick) begin
         start_d = 1'b0;
         up_d    = 1'b0;
         down_d  = 1'b0;
         ai_d    = 1'b1;
         if (gamepad_is_present) begin
            // Pass-through: the player drives, autopilot state is discarded.
            state_d = S_RUN;
            hold_d  = '0;
            cnt_d   = '0;
            start_d = gamepad_start;
            up_d    = gamepad_up;
            down_d  = gamepad_down;
            ai_d    = 1'b0;
         end else if (crash || game_frozen) begin
            // Waiting for restart: pulse start once every RESTART_DELAY+1 ticks.
            state_d = S_WAIT;
            hold_d  = '0;
            if (cnt_q == CNT_LAST) begin
               start_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            case (state_q)
               S_RUN, S_DUCK: begin
                  // Jump wins over duck when both kinds are in the window.
                  if (gnd_hit) begin
                     state_d = S_JUMP;
                     up_d    = 1'b1;
                     hold_d  = HOLD_START;
                  end else if (air_hit) begin
                     state_d = S_DUCK;
                     down_d  = 1'b1;
                  end else begin
                     state_d = S_RUN;
                  end
               end
               S_JUMP: begin
                  // Jump runs to completion; window contents are ignored meanwhile.
                  if (hold_q == '0) begin
                     state_d = S_RUN;
                  end else begin
                     hold_d = hold_q - 1'b1;
                     up_d   = 1'b1;
                  end
               end
               S_WAIT: begin
                  state_d = S_RUN;
                  cnt_d   = '0;
               end
               default: begin
                  state_d = S_RUN;
               end
            endcase
         end
      end
   end

   // State, counters and registered buttons.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         hold_q  <= '0;
         cnt_q   <= '0;
         start_q <= 1'b0;
         up_q    <= 1'b0;
         down_q  <= 1'b0;
         ai_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         up_q    <= up_d;
         down_q  <= down_d;
         ai_q    <= ai_d;
      end
   end

   assign button_start = start_q;
   assign button_up    = up_q;
   assign button_down  = down_q;
   assign ai_active    = ai_q;
   assign dbg_state    = state_q;

endmodule
